// File: rtl/tdm_demux.sv
// tdm_demux: receive end of the TDM link.
// Finds the frame boundary from frame_sync, routes each beat of the W-bit
// serial stream into its channel register, and flags updates, frame
// completion and framing errors. All outputs are registered (1-cycle latency).
//
// Handshake: din is consumed on every clock edge where din_valid=1; there is
// no ready/backpressure, so the upstream may present a valid beat every cycle.
// frame_sync is only meaningful when din_valid=1. ch_valid, frame_done and
// sync_err are single-cycle pulses that qualify the registered outputs.
module tdm_demux #(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [N_CH*W-1:0] ch_data,
    output logic [N_CH-1:0]   ch_valid,
    output logic              frame_done,
    output logic              sync_err,
    output logic              locked
);

    // Slot counter width is derived from N_CH and not meant to be overridden.
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    // Receiver states; `state` is the signal to probe for FSM observation.
    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CW-1:0] SLOT_ZERO = '0;
    localparam logic [CW-1:0] SLOT_ONE  = CW'(1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(N_CH - 1);

    logic [0:0]      state;
    logic [0:0]      state_nxt;
    logic [CW-1:0]   slot;
    logic [CW-1:0]   slot_nxt;

    // Decoded action for the current beat.
    logic            cap_en;
    logic [CW-1:0]   cap_idx;
    logic            done_nxt;
    logic            err_nxt;

    logic [W-1:0]    ch_reg [N_CH];
    logic [N_CH-1:0] cv_reg;
    logic            done_reg;
    logic            err_reg;

    // Decide what the current beat does: capture target, next slot/state, pulses.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        cap_en    = 1'b0;
        cap_idx   = SLOT_ZERO;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;

        if (din_valid) begin
            case (state)
                ST_HUNT: begin
                    // Beats before the first marker are dropped silently.
                    if (frame_sync) begin
                        cap_en    = 1'b1;
                        cap_idx   = SLOT_ZERO;
                        slot_nxt  = SLOT_ONE;
                        state_nxt = ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (frame_sync) begin
                        // A marker always restarts the frame at slot 0; it is
                        // only an error if we were not expecting slot 0.
                        // The aborted frame never reports frame_done.
                        err_nxt  = (slot != SLOT_ZERO);
                        cap_en   = 1'b1;
                        cap_idx  = SLOT_ZERO;
                        slot_nxt = SLOT_ONE;
                    end else if (slot == SLOT_ZERO) begin
                        // Expected a marker and did not get one: lose lock,
                        // drop the beat and go back to hunting.
                        err_nxt   = 1'b1;
                        slot_nxt  = SLOT_ZERO;
                        state_nxt = ST_HUNT;
                    end else begin
                        cap_en  = 1'b1;
                        cap_idx = slot;
                        if (slot == SLOT_LAST) begin
                            slot_nxt = SLOT_ZERO;
                            done_nxt = 1'b1;
                        end else begin
                            slot_nxt = slot + SLOT_ONE;
                        end
                    end
                end

                default: begin
                    state_nxt = ST_HUNT;
                    slot_nxt  = SLOT_ZERO;
                end
            endcase
        end
    end

    // State, slot counter and single-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_HUNT;
            slot     <= SLOT_ZERO;
            cv_reg   <= '0;
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            state    <= state_nxt;
            slot     <= slot_nxt;
            cv_reg   <= cap_en ? (N_CH'(1) << cap_idx) : '0;
            done_reg <= done_nxt;
            err_reg  <= err_nxt;
        end
    end

    // One holding register per channel; values persist across HUNT.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                ch_reg[k] <= '0;
            end else if (cap_en && (cap_idx == CW'(k))) begin
                ch_reg[k] <= din;
            end
        end

        assign ch_data[k*W +: W] = ch_reg[k];
    end

    assign ch_valid   = cv_reg;
    assign frame_done = done_reg;
    assign sync_err   = err_reg;
    assign locked     = (state == ST_RUN);

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: scoreboard bench for tdm_demux with directed and random beats.
module tb_tdm_demux;

    localparam int N_CH = 4;
    localparam int W    = 8;
    localparam int EW   = N_CH*W + N_CH + 3;

    // Clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [W-1:0]      din;
    logic              din_valid;
    logic              frame_sync;
    logic [N_CH*W-1:0] ch_data;
    logic [N_CH-1:0]   ch_valid;
    logic              frame_done;
    logic              sync_err;
    logic              locked;

    tdm_demux #(.N_CH(N_CH), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    // Scoreboard: one expected output snapshot per driven cycle
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: channel contents, next expected slot, lock flag
    logic [W-1:0] m_ch [N_CH];
    int           m_pos = 0;
    bit           m_locked = 1'b0;

    // Driver: apply one cycle of inputs, predict the outputs after the edge
    task automatic step(input bit rstn, input bit v, input bit s, input logic [W-1:0] d);
        logic [N_CH*W-1:0] e_data;
        logic [N_CH-1:0]   e_cv;
        bit                e_fd;
        bit                e_err;
        e_cv  = '0;
        e_fd  = 1'b0;
        e_err = 1'b0;
        rst_n      = rstn;
        din_valid  = v;
        frame_sync = s;
        din        = d;
        if (!rstn) begin
            for (int k = 0; k < N_CH; k++) m_ch[k] = '0;
            m_pos    = 0;
            m_locked = 1'b0;
        end else if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_ch[0]  = d;
                    e_cv[0]  = 1'b1;
                    m_pos    = 1;
                    m_locked = 1'b1;
                end
            end else if (s) begin
                e_err   = (m_pos != 0);
                m_ch[0] = d;
                e_cv[0] = 1'b1;
                m_pos   = 1;
            end else if (m_pos == 0) begin
                e_err    = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_ch[m_pos]  = d;
                e_cv[m_pos]  = 1'b1;
                m_pos        = m_pos + 1;
                if (m_pos == N_CH) begin
                    m_pos = 0;
                    e_fd  = 1'b1;
                end
            end
        end
        for (int k = 0; k < N_CH; k++) e_data[k*W +: W] = m_ch[k];
        exp_q.push_back({e_data, e_cv, e_fd, e_err, m_locked});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, W'($urandom));
    endtask

    // Monitor: compare the DUT outputs against the oldest prediction
    initial begin
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {ch_data, ch_valid, frame_done, sync_err, locked};
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL outputs t=%0t got data=%h cv=%b fd=%b err=%b lk=%b required data=%h cv=%b fd=%b err=%b lk=%b",
                             $time, got[EW-1 -: N_CH*W], got[N_CH+2:3], got[2], got[1], got[0],
                             e[EW-1 -: N_CH*W], e[N_CH+2:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit v;
        bit s;
        int budget;

        // Reset, then beats in HUNT without sync are dropped
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h99);
        step(1'b1, 1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 1'b1, 8'h33);

        // Two clean back-to-back frames
        for (int r = 0; r < 2; r++) begin
            step(1'b1, 1'b1, 1'b1, 8'hA0);
            step(1'b1, 1'b1, 1'b0, 8'hA1);
            step(1'b1, 1'b1, 1'b0, 8'hA2);
            step(1'b1, 1'b1, 1'b0, 8'hA3);
        end

        // Frame with three idle cycles between beats
        for (int k = 0; k < N_CH; k++) begin
            step(1'b1, 1'b1, (k == 0), 8'hB0 + 8'(k));
            idle(3);
        end

        // Resync mid-frame, then finish the new frame
        step(1'b1, 1'b1, 1'b1, 8'h10);
        step(1'b1, 1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b1, 1'b1, 8'h20);
        step(1'b1, 1'b1, 1'b0, 8'h21);
        step(1'b1, 1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b1, 1'b0, 8'h23);

        // Missing sync after a complete frame, then relock
        step(1'b1, 1'b1, 1'b1, 8'h30);
        step(1'b1, 1'b1, 1'b0, 8'h31);
        step(1'b1, 1'b1, 1'b0, 8'h32);
        step(1'b1, 1'b1, 1'b0, 8'h33);
        step(1'b1, 1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b1, 1'b0, 8'h56);
        step(1'b1, 1'b1, 1'b1, 8'h60);
        step(1'b1, 1'b1, 1'b0, 8'h61);
        step(1'b1, 1'b1, 1'b0, 8'h62);
        step(1'b1, 1'b1, 1'b0, 8'h63);

        // Reset arriving together with the slot-2 beat
        step(1'b1, 1'b1, 1'b1, 8'h70);
        step(1'b1, 1'b1, 1'b0, 8'h71);
        step(1'b0, 1'b1, 1'b0, 8'h72);
        step(1'b1, 1'b1, 1'b0, 8'h73);

        // Random traffic: mostly well-formed frames with occasional faults
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ((m_pos == 0) && ($urandom_range(0, 9) != 0)) || ($urandom_range(0, 15) == 0);
            step(($urandom_range(0, 99) != 0), v, s, W'($urandom));
        end
        idle(2);

        // Drain: every prediction must have been matched by a DUT cycle
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain leftover=%0d required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
